// File: rtl/div_seq_ctrl.sv
// Restoring shift-subtract divider controller, one quotient bit per clock, results zero-extended to 2*WIDTH.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor skips iteration and flags div_err on the done cycle.
module div_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q_in,
  input  logic [WIDTH-1:0]   m_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [2*WIDTH-1:0] remainder,
  output logic               div_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t           state, state_nxt;
  // The restored accumulator is always below the divisor, so its sign bit is never stored.
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] qr, qr_nxt;
  logic [WIDTH-1:0] mr, mr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH:0]   acc_sh, acc_sub;
  logic [WIDTH-1:0] qr_sh;
`ifdef DIV_ZERO_TRAP_EN
  logic             trap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    qr_nxt    = qr;
    mr_nxt    = mr;
    cnt_nxt   = cnt;
`ifdef DIV_ZERO_TRAP_EN
    trap      = 1'b0;
`endif
    acc_sh  = {acc, qr[WIDTH-1]};
    acc_sub = acc_sh - {1'b0, mr};
    qr_sh   = {qr[WIDTH-2:0], 1'b0};
    case (state)
      IDLE: begin
        if (start) begin
          qr_nxt    = q_in;
          mr_nxt    = m_in;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = ITER;
`ifdef DIV_ZERO_TRAP_EN
        if (mr == '0) begin
          trap      = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      ITER: begin
        if (acc_sub[WIDTH]) begin
          acc_nxt = acc_sh[WIDTH-1:0];
          qr_nxt  = qr_sh;
        end else begin
          acc_nxt = acc_sub[WIDTH-1:0];
          qr_nxt  = qr_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      qr        <= '0;
      mr        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      acc  <= acc_nxt;
      qr   <= qr_nxt;
      mr   <= mr_nxt;
      cnt  <= cnt_nxt;
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      // Results are taken from the final iteration as DONE is entered.
      if (state == ITER && state_nxt == DONE) begin
        quotient  <= {{WIDTH{1'b0}}, qr_nxt};
        remainder <= {{WIDTH{1'b0}}, acc_nxt};
      end
`ifdef DIV_ZERO_TRAP_EN
      if (trap) begin
        quotient  <= '1;
        remainder <= {{WIDTH{1'b0}}, qr};
      end
`endif
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_err <= 1'b0;
    else        div_err <= trap;
  end
`else
  assign div_err = 1'b0;
`endif

endmodule
